// File: rtl/vga_frame_reader.sv
// vga_frame_reader: read-side SDRAM client that streams one frame per frame_start
// from the MCB read FIFO into the VGA pixel pipe. Ping-pong buffer selection with
// swaps deferred to the next accepted frame_start, and a sticky underrun flag.
module vga_frame_reader #(
  parameter int unsigned FRAME_WORDS   = 786432,
  parameter logic [23:0] BUF0_BASE     = 24'h000000,
  parameter logic [23:0] BUF1_BASE     = 24'h400000,
  parameter int unsigned PREFILL_WORDS = 256,
  parameter logic [15:0] UNDERRUN_PIX  = 16'hF800
) (
  input  logic        clk_mem_rd,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pixel_req,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        swap_req,
  input  logic        clr_underrun,
  output logic        cur_buf,
  output logic        busy,
  output logic        underrun,
  output logic        rd_load,
  output logic [23:0] rd_addr,
  output logic        rd_req,
  input  logic [15:0] dout,
  input  logic [9:0]  rd_fifo_cnt,
  input  logic        rd_fifo_empty,
  input  logic        rd_done
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PREFILL   = 3'd2,
    ST_STREAM    = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic [19:0] r_pix_cnt;
  logic [23:0] r_rd_addr;
  logic        r_rd_load;
  logic        r_done_seen;
  logic        r_cur_buf;
  logic        r_swap_pending;
  logic        r_pix_valid;
  logic        r_popped;
  logic        r_underrun;

  logic w_start;
  logic w_swap;
  logic w_frame_left;
  logic w_rd_req;
  logic w_last_pop;
  logic w_fifo_ready;
  logic w_fill_phase;

  // A frame_start is only honoured from IDLE; a swap applies if pending or arriving now.
  assign w_start      = frame_start & (r_state == ST_IDLE);
  assign w_swap       = r_swap_pending | swap_req;
  assign w_frame_left = (32'(r_pix_cnt) < FRAME_WORDS);
  assign w_fifo_ready = (32'(rd_fifo_cnt) >= PREFILL_WORDS);
  assign w_fill_phase = (r_state == ST_PREFILL) | (r_state == ST_STREAM);

  // NOTE: the FIFO pop must be combinational -- the MCB presents dout the cycle after
  // rd_req, so registering the pop would add a cycle and break the 1-cycle pixel latency.
  assign w_rd_req   = (r_state == ST_STREAM) & pixel_req & ~rd_fifo_empty & w_frame_left;
  assign w_last_pop = w_rd_req & (32'(r_pix_cnt) == FRAME_WORDS - 1);

  // Frame sequencer: load the read burst, wait for prefill, stream, then wait for rd_done.
  // NOTE: every state register here is assigned with <= so all flops update from the
  // same pre-edge values; blocking assignments would create order-dependent logic.
  always_ff @(posedge clk_mem_rd or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pix_cnt   <= 20'd0;
      r_rd_load   <= 1'b0;
      r_rd_addr   <= 24'd0;
      r_done_seen <= 1'b0;
    end else begin
      r_rd_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_LOAD;
            r_rd_load   <= 1'b1;
            r_rd_addr   <= (r_cur_buf ^ w_swap) ? BUF1_BASE : BUF0_BASE;
            r_pix_cnt   <= 20'd0;
            r_done_seen <= 1'b0;
          end
        end
        ST_LOAD: r_state <= ST_PREFILL;
        ST_PREFILL: begin
          if (rd_done) r_done_seen <= 1'b1;
          if (w_fifo_ready) r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (rd_done) r_done_seen <= 1'b1;
          if (w_rd_req) r_pix_cnt <= r_pix_cnt + 20'd1;
          if (w_last_pop) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (rd_done | r_done_seen) begin
            r_state     <= ST_IDLE;
            r_done_seen <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ping-pong select: remember a swap request and apply it at the next accepted frame.
  always_ff @(posedge clk_mem_rd or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_buf      <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (w_start) begin
      if (w_swap) r_cur_buf <= ~r_cur_buf;
      r_swap_pending <= 1'b0;
    end else if (swap_req) begin
      r_swap_pending <= 1'b1;
    end
  end

  // Pixel path: remember whether this cycle's request was backed by a FIFO pop.
  always_ff @(posedge clk_mem_rd or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid <= 1'b0;
      r_popped    <= 1'b0;
    end else begin
      r_pix_valid <= pixel_req;
      r_popped    <= w_rd_req;
    end
  end

  // Sticky underrun: starved pixel while fetching, or a frame_start while busy; set wins.
  always_ff @(posedge clk_mem_rd or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else if ((pixel_req & ~w_rd_req & w_fill_phase) |
                 (frame_start & (r_state != ST_IDLE))) begin
      r_underrun <= 1'b1;
    end else if (clr_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  // dout arrives the cycle after the pop, so the final pixel mux follows the popped flag.
  assign pix_data  = r_popped ? dout : (r_pix_valid ? UNDERRUN_PIX : 16'h0000);
  assign pix_valid = r_pix_valid;
  assign cur_buf   = r_cur_buf;
  assign busy      = (r_state != ST_IDLE);
  assign underrun  = r_underrun;
  assign rd_load   = r_rd_load;
  assign rd_addr   = r_rd_addr;
  assign rd_req    = w_rd_req;

endmodule
